irrigation_countdown_timer: RTL and testbench

IRRIGATION_COUNTDOWN_TIMER -- requirements
Module: irrigation_countdown_timer

---
 rtl/irrigation_countdown_timer.sv | 99 +++++++++
 tb/tb_irrigation_countdown_timer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/irrigation_countdown_timer.sv
// Irrigation valve countdown timer: loads a step count, drives the valve while
// running, and counts down one step every TICK_DIV clock cycles.
module irrigation_countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 10
) (
  input  logic             CP,
  input  logic             RESET,
  input  logic             L,
  input  logic [WIDTH-1:0] D,
  input  logic             C,
  input  logic             ABORT,
  output logic [WIDTH-1:0] Q,
  output logic             VALVE,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       STATE
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n;
  logic [PW-1:0]    pre, pre_n;

  // Abort beats load, load beats ticking; a load on a tick cycle discards the tick.
  always_comb begin
    state_n = state;
    q_n     = Q;
    pre_n   = pre;
    if (ABORT && (state == ST_RUN || state == ST_PAUSE)) begin
      state_n = ST_IDLE;
      q_n     = '0;
      pre_n   = '0;
    end else if (L && (D != '0)) begin
      state_n = C ? ST_RUN : ST_PAUSE;
      q_n     = D;
      pre_n   = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!C) begin
            state_n = ST_PAUSE;
          end else if (pre == LAST) begin
            pre_n = '0;
            if (Q == WIDTH'(1)) begin
              q_n     = '0;
              state_n = ST_DONE;
            end else if (Q != '0) begin
              q_n = Q - WIDTH'(1);
            end
          end else begin
            pre_n = pre + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (C) state_n = ST_RUN;
        end
        ST_DONE: begin
          state_n = ST_IDLE;
          q_n     = '0;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge CP) begin
    if (!RESET) begin
      state <= ST_IDLE;
      Q     <= '0;
      pre   <= '0;
      VALVE <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_n;
      Q     <= q_n;
      pre   <= pre_n;
      VALVE <= (state_n == ST_RUN);
      BUSY  <= (state_n == ST_RUN) || (state_n == ST_PAUSE);
      DONE  <= (state_n == ST_DONE);
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// Bench for irrigation_countdown_timer: directed table, then random stimulus
// against an elapsed-time model, on TICK_DIV=4 and TICK_DIV=1 instances.
module tb_irrigation_countdown_timer;

  logic       CP = 1'b0;
  logic       RESET, L, C, ABORT;
  logic [3:0] D;
  logic [3:0] q0, q1;
  logic       valve0, busy0, done0, valve1, busy1, done1;
  logic [1:0] state0, state1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CP = ~CP;

  irrigation_countdown_timer #(.WIDTH(4), .TICK_DIV(4)) dut4 (
    .CP(CP), .RESET(RESET), .L(L), .D(D), .C(C), .ABORT(ABORT),
    .Q(q0), .VALVE(valve0), .BUSY(busy0), .DONE(done0), .STATE(state0)
  );

  irrigation_countdown_timer #(.WIDTH(4), .TICK_DIV(1)) dut1 (
    .CP(CP), .RESET(RESET), .L(L), .D(D), .C(C), .ABORT(ABORT),
    .Q(q1), .VALVE(valve1), .BUSY(busy1), .DONE(done1), .STATE(state1)
  );

  // Model: remaining = loaded - run_cycles / tick_div; done when run_cycles hits loaded*tick_div.
  int m_mode[2];
  int m_d[2];
  int m_el[2];
  int td[2] = '{4, 1};

  function automatic void model_step(int k);
    if (!RESET) begin
      m_mode[k] = 0; m_d[k] = 0; m_el[k] = 0;
    end else if (ABORT && (m_mode[k] == 1 || m_mode[k] == 2)) begin
      m_mode[k] = 0; m_d[k] = 0; m_el[k] = 0;
    end else if (L && D != 4'd0) begin
      m_d[k] = int'(D); m_el[k] = 0; m_mode[k] = C ? 1 : 2;
    end else begin
      case (m_mode[k])
        1: begin
          if (!C) m_mode[k] = 2;
          else begin
            m_el[k]++;
            if (m_el[k] == m_d[k] * td[k]) m_mode[k] = 3;
          end
        end
        2: if (C) m_mode[k] = 1;
        3: begin m_mode[k] = 0; m_d[k] = 0; m_el[k] = 0; end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [8:0] model_out(int k);
    int q;
    q = (m_mode[k] == 0) ? 0 : m_d[k] - m_el[k] / td[k];
    return {2'(m_mode[k]), 4'(q), m_mode[k] == 1, m_mode[k] == 1 || m_mode[k] == 2, m_mode[k] == 3};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got {state,q,valve,busy,done}=%b expected %b", name, $time, act, exp);
  endtask

  task automatic run_cycle(input logic rst, input logic l, input logic [3:0] d,
                           input logic c, input logic ab);
    @(negedge CP);
    RESET = rst; L = l; D = d; C = c; ABORT = ab;
    model_step(0);
    model_step(1);
    @(posedge CP);
    #1;
    check("model_td4", {state0, q0, valve0, busy0, done0}, model_out(0));
    check("model_td1", {state1, q1, valve1, busy1, done1}, model_out(1));
  endtask

  typedef struct {
    bit         rst;
    bit         l;
    logic [3:0] d;
    bit         c;
    bit         ab;
    int         n;
    logic [1:0] st;
    logic [3:0] q;
    bit         v;
    bit         b;
    bit         dn;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit l, int d, bit c, bit ab, int n,
                              int st, int q, bit v, bit b, bit dn);
    vecs.push_back('{rst, l, 4'(d), c, ab, n, 2'(st), 4'(q), v, b, dn});
  endfunction

  initial begin
    RESET = 1'b0; L = 1'b0; D = 4'd0; C = 1'b0; ABORT = 1'b0;
    for (int k = 0; k < 2; k++) begin m_mode[k] = 0; m_d[k] = 0; m_el[k] = 0; end

    //  rst l  d  c ab  n  st  q  v  b  dn   (outputs after the n-th edge, TICK_DIV=4)
    add(0, 0, 0, 0, 0, 2, 0,  0, 0, 0, 0);   // reset
    add(1, 1, 0, 1, 0, 1, 0,  0, 0, 0, 0);   // zero load ignored
    add(1, 1, 3, 1, 0, 1, 1,  3, 1, 1, 0);   // basic countdown
    add(1, 0, 0, 1, 0, 3, 1,  3, 1, 1, 0);
    add(1, 0, 0, 1, 0, 1, 1,  2, 1, 1, 0);
    add(1, 0, 0, 1, 0, 4, 1,  1, 1, 1, 0);
    add(1, 0, 0, 1, 0, 3, 1,  1, 1, 1, 0);
    add(1, 0, 0, 1, 0, 1, 3,  0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0);
    add(1, 1, 2, 1, 0, 1, 1,  2, 1, 1, 0);   // pause
    add(1, 0, 0, 1, 0, 6, 1,  1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 5, 2,  1, 0, 1, 0);
    add(1, 0, 0, 1, 0, 1, 1,  1, 1, 1, 0);
    add(1, 0, 0, 1, 0, 1, 1,  1, 1, 1, 0);
    add(1, 0, 0, 1, 0, 1, 3,  0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0);
    add(1, 1, 3, 1, 0, 1, 1,  3, 1, 1, 0);   // abort
    add(1, 0, 0, 1, 0, 4, 1,  2, 1, 1, 0);
    add(1, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0);
    add(1, 1, 3, 1, 0, 1, 1,  3, 1, 1, 0);   // reset mid-run
    add(1, 0, 0, 1, 0, 4, 1,  2, 1, 1, 0);
    add(0, 1, 5, 1, 0, 1, 0,  0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 1, 1,  1, 1, 1, 0);   // reload on tick
    add(1, 0, 0, 1, 0, 3, 1,  1, 1, 1, 0);
    add(1, 1, 15, 1, 0, 1, 1, 15, 1, 1, 0);
    add(1, 0, 0, 1, 0, 3, 1, 15, 1, 1, 0);
    add(1, 0, 0, 1, 0, 1, 1, 14, 1, 1, 0);
    add(1, 1, 7, 0, 0, 1, 2,  7, 0, 1, 0);   // load into pause, abort pause
    add(1, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0);

    foreach (vecs[i]) begin
      repeat (vecs[i].n) run_cycle(vecs[i].rst, vecs[i].l, vecs[i].d, vecs[i].c, vecs[i].ab);
      check($sformatf("vec%0d", i), {state0, q0, valve0, busy0, done0},
            {vecs[i].st, vecs[i].q, vecs[i].v, vecs[i].b, vecs[i].dn});
    end

    // DONE state with a new load goes straight back to RUN
    run_cycle(1, 1, 1, 1, 0);
    repeat (4) run_cycle(1, 0, 0, 1, 0);
    run_cycle(1, 1, 2, 1, 0);
    check("reload_from_done", {state0, q0, valve0, busy0, done0}, {2'b01, 4'd2, 1'b1, 1'b1, 1'b0});

    for (int i = 0; i < 1500; i++) begin
      run_cycle($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0,
                4'($urandom_range(0, 15)), $urandom_range(0, 7) != 0,
                $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
